// File: rtl/syzygy_adc_phy_rx.sv
// syzygy_adc_phy_rx: DDR ADC receiver that hunts for a Q/I training pattern,
// locks on either half-cycle pairing and presents aligned I/Q sample pairs.
module syzygy_adc_phy_rx #(
    parameter int                DATA_W     = 12,
    parameter logic [DATA_W-1:0] PAT_Q      = 12'h9A5,
    parameter logic [DATA_W-1:0] PAT_I      = 12'h65A,
    parameter int                LOCK_COUNT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] ddr_d1,
    input  logic [DATA_W-1:0] ddr_d2,
    input  logic              train_en,
    input  logic              realign,
    output logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_q,
    output logic              data_valid,
    output logic              aligned,
    output logic              swapped,
    output logic [15:0]       err_count
);
    localparam int CW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic              swp_q, swp_d;
    logic [15:0]       err_q, err_d;
    logic [DATA_W-1:0] d1_q, d2_q, d2p_q;
    logic [DATA_W-1:0] smp_q_q, smp_i_q;
    logic              valid_q;
    logic              match_n, match_s, match_m;

    assign match_n = (d1_q == PAT_Q) && (d2_q == PAT_I);
    assign match_s = (d2p_q == PAT_Q) && (d1_q == PAT_I);
    assign match_m = swp_q ? match_s : match_n;
    assign cnt_inc = cnt_q + CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1_q    <= '0;
            d2_q    <= '0;
            d2p_q   <= '0;
            smp_q_q <= '0;
            smp_i_q <= '0;
            valid_q <= 1'b0;
        end else begin
            d1_q    <= ddr_d1;
            d2_q    <= ddr_d2;
            d2p_q   <= d2_q;
            smp_q_q <= swp_q ? d2p_q : d1_q;
            smp_i_q <= swp_q ? d1_q : d2_q;
            valid_q <= (state_q == LOCKED) && !train_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            swp_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            swp_q   <= swp_d;
            err_q   <= err_d;
        end
    end

    // Training progress only advances while the far end is sending the pattern.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        swp_d   = swp_q;
        err_d   = err_q;
        if (realign) begin
            state_d = HUNT;
            cnt_d   = '0;
            swp_d   = 1'b0;
        end else if (train_en) begin
            case (state_q)
                HUNT: if (match_n || match_s) begin
                    swp_d   = match_s;
                    cnt_d   = CW'(1);
                    state_d = (LOCK_COUNT <= 1) ? LOCKED : VERIFY;
                end
                VERIFY: if (match_m) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == CW'(LOCK_COUNT)) ? LOCKED : VERIFY;
                end else begin
                    cnt_d   = '0;
                    state_d = HUNT;
                end
                LOCKED: err_d = (!match_m && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
                default: state_d = HUNT;
            endcase
        end
    end

    assign data_q     = smp_q_q;
    assign data_i     = smp_i_q;
    assign data_valid = valid_q;
    assign aligned    = (state_q == LOCKED);
    assign swapped    = swp_q;
    assign err_count  = err_q;
endmodule
